// File: rtl/ice40_serdes_sync_ctrl_if.sv
// Control/status bundle between the SERDES sync sequencer and its surroundings.
// The master side drives lock/restart/sync; the slave side is the sequencer itself.
interface ice40_serdes_sync_ctrl_if;
    logic       pll_lock;
    logic       restart;
    logic       sync;
    logic       sync_rst;
    logic       aligned;
    logic       fault;
    logic [7:0] err_cnt;
    logic [2:0] state;

    modport master (
        output pll_lock, restart, sync,
        input  sync_rst, aligned, fault, err_cnt, state
    );

    modport slave (
        input  pll_lock, restart, sync,
        output sync_rst, aligned, fault, err_cnt, state
    );
endinterface

// File: rtl/ice40_serdes_sync_ctrl.sv
// SERDES clock-phase synchronizer sequencer: waits for PLL lock, pulses the
// synchronizer reset, then qualifies the sync pulse period before reporting alignment.
module ice40_serdes_sync_ctrl #(
    parameter int RATIO     = 4,
    parameter int LOCK_WAIT = 256,
    parameter int RST_HOLD  = 8,
    parameter int FIRST_TMO = 32,
    parameter int CHECK_N   = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    ice40_serdes_sync_ctrl_if.slave ctrl
);

    // states: 0 wait lock | 1 hold sync_rst | 2 await first pulse | 3 qualify period | 4 aligned | 5 fault
    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_HOLD      = 3'd1;
    localparam logic [2:0] S_FIRST     = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_ALIGNED   = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam int LW = $clog2(LOCK_WAIT + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int TW = $clog2(FIRST_TMO + 1);
    localparam int PW = $clog2(RATIO);
    localparam int GW = $clog2(CHECK_N + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_WAIT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(FIRST_TMO - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(RATIO - 1);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(CHECK_N - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    logic [2:0]    r_state;
    logic [LW-1:0] r_lock_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [PW-1:0] r_phase;
    logic [GW-1:0] r_good_cnt;
    logic [RW-1:0] r_retry;
    logic [7:0]    r_err_cnt;
    logic          r_sync_rst;
    logic          r_aligned;
    logic          r_fault;

    logic [2:0]    w_state_nxt;
    logic [RW-1:0] w_retry_inc;
    logic          w_phase_last;
    logic          w_good;
    logic          w_err;
    logic          w_fail;
    logic          w_lock_done;
    logic          w_check_done;
    logic          w_restart;
    logic          w_ovr;
    logic          w_attempt_fail;
    logic          w_err_hit;
    logic          w_retry_clr;
    logic          w_in_track;
    logic          w_stay_track;

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_last = (r_phase == PHASE_LAST);
        w_good       = 1'b0;
        w_err        = 1'b0;
        w_fail       = 1'b0;
        w_lock_done  = 1'b0;
        w_check_done = 1'b0;
        w_restart    = ctrl.pll_lock && ctrl.restart;
        w_ovr        = !ctrl.pll_lock || ctrl.restart;
        w_retry_inc  = r_retry + RW'(1);

        case (r_state)
            S_WAIT_LOCK: begin
                if (ctrl.pll_lock && r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_lock_done = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_FIRST;
            end
            S_FIRST: begin
                if (ctrl.sync) w_state_nxt = S_CHECK;
                else if (r_tmo_cnt == TMO_LAST) w_fail = 1'b1;
            end
            S_CHECK, S_ALIGNED: begin
                w_good = ctrl.sync && w_phase_last;
                w_err  = ctrl.sync != w_phase_last;
                if (w_err) begin
                    w_fail = 1'b1;
                end else if (r_state == S_CHECK && w_good && r_good_cnt == GOOD_LAST) begin
                    w_state_nxt  = S_ALIGNED;
                    w_check_done = 1'b1;
                end
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_WAIT_LOCK;
        endcase

        if (w_fail) w_state_nxt = (w_retry_inc >= RETRY_MAX) ? S_FAULT : S_HOLD;

        // Lock loss beats restart, and both beat whatever the pulse checker decided.
        if (!ctrl.pll_lock) begin
            if (r_state != S_WAIT_LOCK) w_state_nxt = S_WAIT_LOCK;
        end else if (ctrl.restart) begin
            w_state_nxt = S_HOLD;
        end

        w_attempt_fail = w_fail && !w_ovr;
        w_err_hit      = w_err && (r_state == S_ALIGNED) && !w_ovr;
        w_retry_clr    = w_restart || ((w_lock_done || w_check_done) && !w_ovr);
        w_in_track     = (r_state == S_CHECK) || (r_state == S_ALIGNED);
        w_stay_track   = w_in_track && ((w_state_nxt == S_CHECK) || (w_state_nxt == S_ALIGNED));
    end

    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            r_state    <= S_WAIT_LOCK;
            r_lock_cnt <= '0;
            r_hold_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_phase    <= '0;
            r_good_cnt <= '0;
            r_retry    <= '0;
            r_err_cnt  <= '0;
            r_sync_rst <= 1'b1;
            r_aligned  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_WAIT_LOCK && w_state_nxt == S_WAIT_LOCK && ctrl.pll_lock)
                r_lock_cnt <= r_lock_cnt + LW'(1);
            else
                r_lock_cnt <= '0;

            // A restart while already holding starts a fresh full-length hold.
            if (r_state == S_HOLD && w_state_nxt == S_HOLD && !w_restart)
                r_hold_cnt <= r_hold_cnt + HW'(1);
            else
                r_hold_cnt <= '0;

            if (r_state == S_FIRST && w_state_nxt == S_FIRST)
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            else
                r_tmo_cnt <= '0;

            if (w_stay_track)
                r_phase <= w_phase_last ? '0 : r_phase + PW'(1);
            else
                r_phase <= '0;

            if (r_state == S_CHECK && w_state_nxt == S_CHECK) begin
                if (w_good) r_good_cnt <= r_good_cnt + GW'(1);
            end else begin
                r_good_cnt <= '0;
            end

            if (w_retry_clr)         r_retry <= '0;
            else if (w_attempt_fail) r_retry <= w_retry_inc;

            if (w_err_hit && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;

            r_sync_rst <= !((w_state_nxt == S_FIRST) || (w_state_nxt == S_CHECK) ||
                            (w_state_nxt == S_ALIGNED));
            r_aligned  <= (w_state_nxt == S_ALIGNED);
            r_fault    <= (w_state_nxt == S_FAULT);
        end
    end

    assign ctrl.sync_rst = r_sync_rst;
    assign ctrl.aligned  = r_aligned;
    assign ctrl.fault    = r_fault;
    assign ctrl.err_cnt  = r_err_cnt;
    assign ctrl.state    = r_state;

endmodule

// File: tb/tb_ice40_serdes_sync_ctrl.sv
// Directed bench for the SERDES sync sequencer: lock wait, alignment, error
// handling, retry/fault, restart, lock loss and err_cnt saturation.
module tb_ice40_serdes_sync_ctrl;

    logic clk_fast;
    logic rst;

    ice40_serdes_sync_ctrl_if bus ();

    ice40_serdes_sync_ctrl #(
        .RATIO(4), .LOCK_WAIT(256), .RST_HOLD(8),
        .FIRST_TMO(32), .CHECK_N(8), .MAX_RETRY(3)
    ) dut (
        .clk_fast(clk_fast),
        .rst     (rst),
        .ctrl    (bus)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    int vec;
    int miscmp;

    // sync pulse generator, advanced once per step from the stimulus process
    logic gen_on;
    int   gen_per;
    int   gen_cnt;
    logic gen_skip;

    localparam int C_ALIGNED_HI = 0;
    localparam int C_ALIGNED_LO = 1;
    localparam int C_SRST_LO    = 2;
    localparam int C_FAULT_HI   = 3;
    localparam int C_ST_HOLD    = 4;
    localparam int C_ST_CHECK   = 5;

    task automatic step();
        @(negedge clk_fast);
        if (gen_on) begin
            gen_cnt = (gen_cnt == gen_per - 1) ? 0 : gen_cnt + 1;
            if (gen_cnt == gen_per - 1) begin
                if (gen_skip) begin
                    gen_skip = 1'b0;
                    bus.sync = 1'b0;
                end else begin
                    bus.sync = 1'b1;
                end
            end else begin
                bus.sync = 1'b0;
            end
        end else begin
            bus.sync = 1'b0;
        end
    endtask

    function automatic logic cond_met(input int c);
        case (c)
            C_ALIGNED_HI: return bus.aligned === 1'b1;
            C_ALIGNED_LO: return bus.aligned === 1'b0;
            C_SRST_LO:    return bus.sync_rst === 1'b0;
            C_FAULT_HI:   return bus.fault === 1'b1;
            C_ST_HOLD:    return bus.state === 3'd1;
            C_ST_CHECK:   return bus.state === 3'd3;
            default:      return 1'b0;
        endcase
    endfunction

    task automatic wait_cond(input int c, input int bound, output int n);
        n = 0;
        while (!cond_met(c) && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        step();
        step();
        vec++; if (bus.state !== 3'd0) begin miscmp++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        vec++; if (bus.sync_rst !== 1'b1) begin miscmp++; $display("FAIL reset_sync_rst: got %b want 1", bus.sync_rst); end
        vec++; if (bus.aligned !== 1'b0 || bus.fault !== 1'b0) begin miscmp++; $display("FAIL reset_flags: aligned %b fault %b want 0 0", bus.aligned, bus.fault); end
        vec++; if (bus.err_cnt !== 8'd0) begin miscmp++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_nominal();
        int n;
        rst = 1'b0;
        bus.pll_lock = 1'b1;
        wait_cond(C_SRST_LO, 400, n);
        vec++; if (n != 264) begin miscmp++; $display("FAIL nominal_release_delay: got %0d cycles want 264", n); end
        gen_on = 1'b1; gen_per = 4; gen_cnt = 1; gen_skip = 1'b0;
        wait_cond(C_ALIGNED_HI, 200, n);
        vec++; if (n != 35) begin miscmp++; $display("FAIL nominal_align_delay: got %0d cycles want 35", n); end
        vec++; if (bus.state !== 3'd4 || bus.sync_rst !== 1'b0) begin miscmp++; $display("FAIL nominal_aligned_state: state %0d sync_rst %b want 4 0", bus.state, bus.sync_rst); end
        vec++; if (bus.err_cnt !== 8'd0) begin miscmp++; $display("FAIL nominal_err_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_missing_pulse();
        int n;
        gen_skip = 1'b1;
        wait_cond(C_ALIGNED_LO, 20, n);
        vec++; if (n != 4) begin miscmp++; $display("FAIL missing_drop_delay: got %0d cycles want 4", n); end
        vec++; if (bus.err_cnt !== 8'd1) begin miscmp++; $display("FAIL missing_err_cnt: got %0d want 1", bus.err_cnt); end
        vec++; if (bus.state !== 3'd1 || bus.sync_rst !== 1'b1) begin miscmp++; $display("FAIL missing_retry_hold: state %0d sync_rst %b want 1 1", bus.state, bus.sync_rst); end
        wait_cond(C_SRST_LO, 30, n);
        vec++; if (n != 8) begin miscmp++; $display("FAIL missing_hold_len: got %0d cycles want 8", n); end
        wait_cond(C_ALIGNED_HI, 200, n);
        vec++; if (bus.aligned !== 1'b1 || bus.err_cnt !== 8'd1) begin miscmp++; $display("FAIL missing_realign: aligned %b err_cnt %0d want 1 1", bus.aligned, bus.err_cnt); end
    endtask

    task automatic test_early_pulse();
        int   n;
        int   falls;
        int   bad;
        logic prev;
        gen_per = 3; gen_cnt = 0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        vec++; if (bus.state !== 3'd1) begin miscmp++; $display("FAIL early_restart_hold: state %0d want 1", bus.state); end
        falls = 0; n = 0; prev = bus.sync_rst;
        while (bus.fault !== 1'b1 && n < 500) begin
            step();
            n++;
            if (prev === 1'b1 && bus.sync_rst === 1'b0) falls++;
            prev = bus.sync_rst;
        end
        vec++; if (falls != 3) begin miscmp++; $display("FAIL early_attempts: got %0d attempts want 3", falls); end
        vec++; if (bus.state !== 3'd5 || bus.fault !== 1'b1 || bus.sync_rst !== 1'b1) begin miscmp++; $display("FAIL early_fault: state %0d fault %b sync_rst %b want 5 1 1", bus.state, bus.fault, bus.sync_rst); end
        vec++; if (bus.err_cnt !== 8'd1 || bus.aligned !== 1'b0) begin miscmp++; $display("FAIL early_err_cnt: err_cnt %0d aligned %b want 1 0", bus.err_cnt, bus.aligned); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.state !== 3'd5 || bus.fault !== 1'b1 || bus.sync_rst !== 1'b1) bad++;
        end
        vec++; if (bad != 0) begin miscmp++; $display("FAIL early_fault_sticky: left fault in %0d cycles want 0", bad); end
    endtask

    task automatic test_fault_exit();
        int n;
        gen_per = 4; gen_cnt = 0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        vec++; if (bus.state !== 3'd1 || bus.fault !== 1'b0) begin miscmp++; $display("FAIL exit_hold: state %0d fault %b want 1 0", bus.state, bus.fault); end
        wait_cond(C_ALIGNED_HI, 200, n);
        vec++; if (bus.aligned !== 1'b1 || bus.state !== 3'd4) begin miscmp++; $display("FAIL exit_realign: aligned %b state %0d want 1 4", bus.aligned, bus.state); end
    endtask

    task automatic test_first_timeout();
        int n;
        gen_on = 1'b0;
        bus.sync = 1'b0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        wait_cond(C_FAULT_HI, 200, n);
        vec++; if (n + 1 != 121) begin miscmp++; $display("FAIL timeout_to_fault: got %0d cycles want 121", n + 1); end
        vec++; if (bus.state !== 3'd5) begin miscmp++; $display("FAIL timeout_state: got %0d want 5", bus.state); end
    endtask

    task automatic test_lock_loss();
        int n;
        gen_on = 1'b1; gen_per = 4; gen_cnt = 0; gen_skip = 1'b0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        wait_cond(C_ST_CHECK, 100, n);
        vec++; if (bus.state !== 3'd3) begin miscmp++; $display("FAIL lock_reach_check: state %0d want 3", bus.state); end
        step();
        step();
        bus.pll_lock = 1'b0;
        step();
        bus.pll_lock = 1'b1;
        vec++; if (bus.state !== 3'd0 || bus.sync_rst !== 1'b1 || bus.aligned !== 1'b0) begin miscmp++; $display("FAIL lock_drop: state %0d sync_rst %b aligned %b want 0 1 0", bus.state, bus.sync_rst, bus.aligned); end
        wait_cond(C_ST_HOLD, 400, n);
        vec++; if (n != 256) begin miscmp++; $display("FAIL lock_rewait: got %0d cycles want 256", n); end
        wait_cond(C_ALIGNED_HI, 200, n);
        vec++; if (bus.aligned !== 1'b1) begin miscmp++; $display("FAIL lock_realign: aligned %b want 1", bus.aligned); end
    endtask

    task automatic test_saturation_reset();
        int n;
        int exp_err;
        exp_err = 1;
        for (int i = 0; i < 300; i++) begin
            gen_skip = 1'b1;
            wait_cond(C_ALIGNED_LO, 20, n);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            vec++; if (bus.err_cnt !== 8'(exp_err)) begin miscmp++; $display("FAIL sat_err_cnt[%0d]: got %0d want %0d", i, bus.err_cnt, exp_err); end
            wait_cond(C_ALIGNED_HI, 200, n);
            vec++; if (bus.aligned !== 1'b1) begin miscmp++; $display("FAIL sat_realign[%0d]: aligned %b want 1", i, bus.aligned); end
        end
        vec++; if (bus.err_cnt !== 8'd255) begin miscmp++; $display("FAIL sat_final: got %0d want 255", bus.err_cnt); end
        step();
        #2 rst = 1'b1;
        #1;
        vec++; if (bus.err_cnt !== 8'd0) begin miscmp++; $display("FAIL async_rst_err_cnt: got %0d want 0", bus.err_cnt); end
        vec++; if (bus.state !== 3'd0 || bus.sync_rst !== 1'b1) begin miscmp++; $display("FAIL async_rst_state: state %0d sync_rst %b want 0 1", bus.state, bus.sync_rst); end
        vec++; if (bus.aligned !== 1'b0 || bus.fault !== 1'b0) begin miscmp++; $display("FAIL async_rst_flags: aligned %b fault %b want 0 0", bus.aligned, bus.fault); end
        step();
        step();
    endtask

    initial begin
        vec = 0; miscmp = 0;
        gen_on = 1'b0; gen_per = 4; gen_cnt = 0; gen_skip = 1'b0;
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        bus.sync     = 1'b0;
        test_reset();
        test_nominal();
        test_missing_pulse();
        test_early_pulse();
        test_fault_exit();
        test_first_timeout();
        test_lock_loss();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule

// File: doc/ice40_serdes_sync_ctrl.md
# ice40_serdes_sync_ctrl

Controller that sequences the SERDES clock-phase synchronizer. It waits for PLL lock and holds the synchronizer in reset. After release it checks that the `sync` pulse train arrives with the expected period, then reports alignment. On loss of alignment it retries, and after repeated failures it parks in a fault state. It runs entirely in the fast SERDES clock domain: it drives the synchronizer's reset and consumes its non-buffered `sync` output.

## Interface

Parameters:

- `RATIO`, 4: fast/slow clock ratio, which is the expected `sync` period in `clk_fast` cycles; 2..16.
- `LOCK_WAIT`, 256: number of consecutive cycles `pll_lock` must be high before sequencing starts; 1..65535.
- `RST_HOLD`, 8: number of cycles `sync_rst` is held high in HOLD; 1..255.
- `FIRST_TMO`, 32: maximum number of cycles from reset release to the first `sync` pulse; > `RATIO`.
- `CHECK_N`, 8: number of consecutive correctly spaced pulses required before declaring alignment; 1..255.
- `MAX_RETRY`, 3: number of consecutive failed attempts before entering FAULT; 1..15.

Ports:

- `clk_fast`, in, 1: fast SERDES clock; the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `pll_lock`, in, 1: PLL lock indicator, already synchronized to `clk_fast`.
- `restart`, in, 1: single-cycle pulse that leaves FAULT, or forces a new attempt from any state.
- `sync`, in, 1: pulse output of the synchronizer.
- `sync_rst`, out, 1: reset to the synchronizer; registered.
- `aligned`, out, 1: high only in ALIGNED; registered.
- `fault`, out, 1: high only in FAULT; registered.
- `err_cnt`, out, 8: saturating count of alignment losses detected in ALIGNED.
- `state`, out, 3: state encoding, for debug.

## Operation

States and encodings: WAIT_LOCK=0, HOLD=1, FIRST=2, CHECK=3, ALIGNED=4, FAULT=5.

- **WAIT_LOCK**
  - `sync_rst`=1.
  - A lock counter counts consecutive cycles with `pll_lock`=1; it clears to 0 whenever `pll_lock`=0.
  - When the counter reaches `LOCK_WAIT`: go to HOLD, clear the retry counter.
- **HOLD**
  - `sync_rst`=1 for `RST_HOLD` cycles, then go to FIRST.
- **FIRST**
  - `sync_rst`=0; a timeout counter runs.
  - `sync`=1: load the phase counter with 0, clear the good-pulse count, go to CHECK.
  - Timeout counter reaches `FIRST_TMO` with no pulse: the attempt fails.
- **CHECK / ALIGNED**
  - The phase counter increments every cycle, modulo `RATIO`.
  - `sync`=1 with phase=`RATIO-1` is a good pulse. In CHECK it increments the good count; at `CHECK_N` go to ALIGNED and clear the retry counter.
  - `sync`=1 at any other phase is an error.
  - `sync`=0 at phase=`RATIO-1` is an error.
  - Error in CHECK: the attempt fails.
  - Error in ALIGNED: `err_cnt` increments (saturating at 255), then the attempt fails.
- **Attempt failure**
  - Retry counter +1.
  - If the retry counter is now ≥ `MAX_RETRY`: go to FAULT; otherwise go to HOLD.
- **FAULT**
  - `sync_rst`=1, `fault`=1.
  - Leaves FAULT only on `restart` or on a drop of `pll_lock`.
- **Global overrides**, evaluated every cycle:
  - `pll_lock`=0 in any state except WAIT_LOCK: go to WAIT_LOCK.
  - `restart`=1 when the lock override does not apply: go to HOLD and clear the retry counter.
  - Lock loss has priority over `restart`.
- **Counters**
  - `err_cnt` is cleared only by `rst`.
  - Counter widths are sized from their parameters with `$clog2`.
  - No counter wraps.

## Timing

- **Reset values:** state=WAIT_LOCK, `sync_rst`=1, `aligned`=0, `fault`=0, `err_cnt`=0, all internal counters 0.
- All outputs are registered and change on the `clk_fast` edge after the state transition that causes them.
- `sync_rst` falls on the first cycle of FIRST. It therefore stays high for exactly `RST_HOLD` cycles per HOLD visit.
- `aligned` rises in the cycle after the `CHECK_N`-th good pulse is sampled.
- `aligned` falls in the cycle after an error is sampled; `err_cnt` updates in that same cycle.
- `pll_lock` falling: `sync_rst`=1 and `aligned`=0 one cycle later.
- Asserting `rst` mid-operation forces all reset values immediately, independent of the clock.
- `sync` and `restart` asserted in the same cycle: `restart` wins, and the pulse is ignored.

## Test plan

- **Nominal lock:** `rst` released, `pll_lock`=1 steady, `RATIO`=4, `sync` every 4 cycles starting 3 cycles after release. Required: `sync_rst` low exactly 256+8 cycles after lock; `aligned`=1 one cycle after the 8th good pulse; `err_cnt`=0.
- **Missing pulse in ALIGNED:** after alignment, suppress one `sync` pulse. Required: `aligned`=0 the next cycle, `err_cnt`=1, `sync_rst` high for 8 cycles, then re-alignment.
- **Early pulse in CHECK:** inject pulses spaced 3 cycles apart. Required: retry via HOLD. After 3 consecutive failures: `fault`=1, `sync_rst`=1, state=5, and the block stays there with `sync` toggling.
- **FAULT exit:** from FAULT, pulse `restart`. Required: state HOLD next cycle, retry counter 0, and alignment succeeds with good stimulus.
- **Lock loss mid-CHECK:** drop `pll_lock` for 1 cycle. Required: WAIT_LOCK next cycle, `sync_rst`=1, full 256-cycle wait before HOLD.
- **Saturation and reset:** force 300 alignment losses. Required: `err_cnt` holds at 255; asserting `rst` asynchronously clears it and all outputs to reset values.
